// File: rtl/demux_route_buffer.sv
// Queues (data, destination) words and feeds the head to a four-way demux.
// The head retires only when its addressed lane is ready, so each lane gets its own backpressure.
module demux_route_buffer #(
  parameter int BITS  = 4,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       FLUSH,
  input  logic [BITS-1:0]            IN_DATA,
  input  logic [1:0]                 IN_DEST,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  output logic [BITS-1:0]            DEMUX_DATA,
  output logic [1:0]                 DEMUX_SELECT,
  output logic [3:0]                 LANE_VALID,
  input  logic [3:0]                 LANE_READY,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       FULL,
  output logic                       EMPTY
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = BITS + 2;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          empty, full, push, pop;
  logic [EW-1:0] head;

  always_comb begin
    head  = mem_q[rd_ptr_q];
    empty = (count_q == '0);
    full  = (count_q == CW'(DEPTH));
    push  = IN_VALID && !full;
    // Only the addressed lane's ready matters; other lanes are ignored.
    pop   = !empty && LANE_READY[head[EW-1:EW-2]];

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: everything read from it is masked while empty.
  always_ff @(posedge CLK) begin
    if (push && !FLUSH) mem_q[wr_ptr_q] <= {IN_DEST, IN_DATA};
  end

  always_comb begin
    IN_READY     = !full;
    COUNT        = count_q;
    FULL         = full;
    EMPTY        = empty;
    DEMUX_DATA   = '0;
    DEMUX_SELECT = '0;
    LANE_VALID   = '0;
    if (!empty) begin
      DEMUX_DATA   = head[BITS-1:0];
      DEMUX_SELECT = head[EW-1:EW-2];
      LANE_VALID   = 4'b0001 << head[EW-1:EW-2];
    end
  end

endmodule

// File: tb/tb_demux_route_buffer.sv
// Bench for demux_route_buffer: directed scenarios plus random traffic, all
// checked against a queue-based model of the routing buffer.
module tb_demux_route_buffer;

  localparam int BITS  = 4;
  localparam int DEPTH = 4;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic            FLUSH = 1'b0;
  logic [BITS-1:0] IN_DATA = '0;
  logic [1:0]      IN_DEST = '0;
  logic            IN_VALID = 1'b0;
  logic            IN_READY;
  logic [BITS-1:0] DEMUX_DATA;
  logic [1:0]      DEMUX_SELECT;
  logic [3:0]      LANE_VALID;
  logic [3:0]      LANE_READY = '0;
  logic [2:0]      COUNT;
  logic            FULL;
  logic            EMPTY;

  typedef struct packed {
    logic [1:0]      dest;
    logic [BITS-1:0] data;
  } entry_t;

  entry_t model_q[$];
  int     tests_run = 0;
  int     tests_failed = 0;

  demux_route_buffer #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_DATA(IN_DATA), .IN_DEST(IN_DEST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .DEMUX_DATA(DEMUX_DATA), .DEMUX_SELECT(DEMUX_SELECT), .LANE_VALID(LANE_VALID),
    .LANE_READY(LANE_READY), .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Compare every output against what the queue model says right now.
  task automatic checkAll();
    int sz;
    sz = model_q.size();
    checkOutput("count", 32'(COUNT), 32'(sz));
    checkOutput("empty", 32'(EMPTY), 32'(sz == 0));
    checkOutput("full", 32'(FULL), 32'(sz == DEPTH));
    checkOutput("in_ready", 32'(IN_READY), 32'(sz < DEPTH));
    checkOutput("demux_data", 32'(DEMUX_DATA), sz > 0 ? 32'(model_q[0].data) : 32'd0);
    checkOutput("demux_select", 32'(DEMUX_SELECT), sz > 0 ? 32'(model_q[0].dest) : 32'd0);
    checkOutput("lane_valid", 32'(LANE_VALID), sz > 0 ? (32'd1 << model_q[0].dest) : 32'd0);
  endtask

  // One clock: check at the falling edge, drive, then advance the model at the rising edge.
  task automatic applyStimulus(input bit flush, input bit valid, input logic [BITS-1:0] data,
                               input logic [1:0] dest, input logic [3:0] ready);
    bit     do_push, do_pop;
    entry_t e;
    @(negedge CLK);
    checkAll();
    FLUSH = flush; IN_VALID = valid; IN_DATA = data; IN_DEST = dest; LANE_READY = ready;
    do_push = valid && (model_q.size() < DEPTH);
    do_pop  = (model_q.size() > 0) && ready[model_q[0].dest];
    @(posedge CLK);
    if (flush) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.data = data;
        e.dest = dest;
        model_q.push_back(e);
      end
    end
  endtask

  task automatic pulseReset();
    @(negedge CLK);
    IN_VALID = 1'b0; FLUSH = 1'b0;
    #1 RESET = 1'b1;
    #1;
    checkOutput("async_rst_count", 32'(COUNT), 32'd0);
    checkOutput("async_rst_empty", 32'(EMPTY), 32'd1);
    checkOutput("async_rst_lane_valid", 32'(LANE_VALID), 32'd0);
    checkOutput("async_rst_data", 32'(DEMUX_DATA), 32'd0);
    model_q.delete();
    #1 RESET = 1'b0;
  endtask

  bit             hold;
  bit             r_valid, r_flush;
  logic [BITS-1:0] r_data;
  logic [1:0]     r_dest;
  logic [3:0]     r_ready;

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // Reset state
    checkOutput("rst_count", 32'(COUNT), 32'd0);
    checkOutput("rst_empty", 32'(EMPTY), 32'd1);
    checkOutput("rst_in_ready", 32'(IN_READY), 32'd1);
    checkOutput("rst_lane_valid", 32'(LANE_VALID), 32'd0);
    checkOutput("rst_data", 32'(DEMUX_DATA), 32'd0);
    checkOutput("rst_select", 32'(DEMUX_SELECT), 32'd0);

    // Single word to lane 2, popped on the following edge
    applyStimulus(0, 1, 4'hA, 2'd2, 4'b1111);
    #1;
    checkOutput("single_data", 32'(DEMUX_DATA), 32'hA);
    checkOutput("single_lane_valid", 32'(LANE_VALID), 32'b0100);
    applyStimulus(0, 0, 4'h0, 2'd0, 4'b1111);
    #1;
    checkOutput("single_empty_after", 32'(EMPTY), 32'd1);

    // Fill with lanes stalled, try a fifth word, then drain in order
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 4'(i + 1), 2'(i), 4'b0000);
    #1;
    checkOutput("fill_full", 32'(FULL), 32'd1);
    checkOutput("fill_in_ready", 32'(IN_READY), 32'd0);
    applyStimulus(0, 1, 4'hF, 2'd0, 4'b0000);
    #1;
    checkOutput("fifth_rejected_count", 32'(COUNT), 32'd4);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 4'h0, 2'd0, 4'b1111);

    // Stall on lane 3, then release it
    applyStimulus(0, 1, 4'h5, 2'd3, 4'b0111);
    applyStimulus(0, 0, 4'h0, 2'd0, 4'b0111);
    applyStimulus(0, 0, 4'h0, 2'd0, 4'b0111);
    #1;
    checkOutput("stall_count", 32'(COUNT), 32'd1);
    checkOutput("stall_lane_valid", 32'(LANE_VALID), 32'b1000);
    applyStimulus(0, 0, 4'h0, 2'd0, 4'b1000);
    #1;
    checkOutput("stall_released_empty", 32'(EMPTY), 32'd1);

    // Simultaneous push/pop at COUNT=2, then ten push/pop pairs across the wrap
    applyStimulus(0, 1, 4'h1, 2'd1, 4'b0000);
    applyStimulus(0, 1, 4'h2, 2'd2, 4'b0000);
    applyStimulus(0, 1, 4'h3, 2'd0, 4'b1111);
    #1;
    checkOutput("pushpop_count", 32'(COUNT), 32'd2);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 4'(i), 2'(i % 4), 4'b1111);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4'h0, 2'd0, 4'b1111);

    // Flush with a simultaneous push at COUNT=3
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 4'(i + 6), 2'd1, 4'b0000);
    applyStimulus(1, 1, 4'hC, 2'd2, 4'b1111);
    #1;
    checkOutput("flush_count", 32'(COUNT), 32'd0);
    checkOutput("flush_empty", 32'(EMPTY), 32'd1);

    // Async reset mid-queue
    applyStimulus(0, 1, 4'h7, 2'd1, 4'b0000);
    applyStimulus(0, 1, 4'h8, 2'd2, 4'b0000);
    pulseReset();
    applyStimulus(0, 0, 4'h0, 2'd0, 4'b0000);

    // Random traffic, holding the word while it is not accepted
    hold = 0;
    r_data = '0; r_dest = '0;
    for (int n = 0; n < 600; n++) begin
      if (!hold) begin
        r_valid = ($urandom_range(0, 2) != 0);
        r_data  = 4'($urandom);
        r_dest  = 2'($urandom);
      end else begin
        r_valid = 1'b1;
      end
      r_flush = ($urandom_range(0, 40) == 0);
      r_ready = 4'($urandom);
      hold = r_valid && !r_flush && (model_q.size() == DEPTH);
      applyStimulus(r_flush, r_valid, r_data, r_dest, r_ready);
      if (n == 300) pulseReset();
      if (n == 300) hold = 0;
    end
    @(negedge CLK);
    checkAll();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
